// File: rtl/ws_disp_pkg.sv
// rtl/ws_disp_pkg.sv - shared ws display types and constants
package ws_disp_pkg;

    // Nibbles per sequencer word held in each snapshot bank
    localparam int NIBBLES = 14;
    localparam logic [3:0] LAST_IDX = 4'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } snap_state_t;

endpackage

// File: rtl/ws_pace_strobe.sv
// rtl/ws_pace_strobe.sv - periodic one-cycle fetch strobe generator
module ws_pace_strobe #(
    parameter int PERIOD = 16
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic i_en,
    input  logic i_restart,
    output logic o_strobe
);

    localparam logic [7:0] LAST = 8'(PERIOD - 1);

    logic [7:0] r_count;

    // Count cycles while enabled; a restart zeroes the count so the first
    // strobe lands PERIOD cycles after the restart cycle
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_count <= 8'd0;
        end else if (i_restart) begin
            r_count <= 8'd0;
        end else if (i_en) begin
            r_count <= (r_count == LAST) ? 8'd0 : r_count + 8'd1;
        end
    end

    assign o_strobe = i_en & ~i_restart & (r_count == LAST);

endmodule

// File: rtl/ws_disp_snapshot.sv
// rtl/ws_disp_snapshot.sv - double-buffered snapshot of sequencer A/B nibbles
module ws_disp_snapshot
    import ws_disp_pkg::*;
#(
    parameter int FETCH_PERIOD = 16
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       acq_in,
    input  logic       seq_word_start_in,
    input  logic       seq_nibble_valid_in,
    input  logic [3:0] a_nibble_in,
    input  logic [3:0] b_nibble_in,
    input  logic [3:0] rd_index_in,
    output logic [3:0] ra_o,
    output logic [3:0] rb_o,
    output logic       fetch_strobe_o,
    output logic       snap_valid_o,
    output logic       busy_o
);

    snap_state_t r_state;
    snap_state_t w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [3:0]  w_wr_idx;
    logic        w_wr;
    logic        w_copy;
    logic        w_start;
    logic        r_pending;
    logic        r_snap_valid;

    logic [3:0] r_sh_a [NIBBLES];
    logic [3:0] r_sh_b [NIBBLES];
    logic [3:0] r_fr_a [NIBBLES];
    logic [3:0] r_fr_b [NIBBLES];

    assign w_start = seq_word_start_in & seq_nibble_valid_in;

    // State and nibble counter registers
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state, shadow write control and front-bank copy request
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_wr       = 1'b0;
        w_wr_idx   = r_cnt;
        w_copy     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (acq_in) w_next = ST_ARM;
            end
            ST_ARM: begin
                if (w_start) begin
                    w_wr       = 1'b1;
                    w_wr_idx   = 4'd0;
                    w_cnt_next = 4'd1;
                    w_next     = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (w_start) begin
                    w_wr       = 1'b1;
                    w_wr_idx   = 4'd0;
                    w_cnt_next = 4'd1;
                end else if (seq_nibble_valid_in) begin
                    w_wr = 1'b1;
                    if (r_cnt == LAST_IDX) begin
                        w_cnt_next = 4'd0;
                        w_next     = ST_DONE;
                    end else begin
                        w_cnt_next = r_cnt + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                w_copy     = 1'b1;
                w_cnt_next = 4'd0;
                w_next     = (r_pending | acq_in) ? ST_ARM : ST_IDLE;
            end
            default: begin
                w_next     = ST_IDLE;
                w_cnt_next = 4'd0;
            end
        endcase
    end

    // Single pending request: latched while busy, consumed when DONE exits
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_pending <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_pending <= 1'b0;
        end else if (acq_in && (r_state != ST_IDLE)) begin
            r_pending <= 1'b1;
        end
    end

    // Shadow banks take live nibbles; front banks only change in DONE
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < NIBBLES; i++) begin
                r_sh_a[i] <= 4'h0;
                r_sh_b[i] <= 4'h0;
                r_fr_a[i] <= 4'h0;
                r_fr_b[i] <= 4'h0;
            end
            r_snap_valid <= 1'b0;
        end else begin
            if (w_wr) begin
                r_sh_a[w_wr_idx] <= a_nibble_in;
                r_sh_b[w_wr_idx] <= b_nibble_in;
            end
            if (w_copy) begin
                r_fr_a       <= r_sh_a;
                r_fr_b       <= r_sh_b;
                r_snap_valid <= 1'b1;
            end
        end
    end

    // Front-bank read port; indices beyond the word read as zero
    always_comb begin
        ra_o = 4'h0;
        rb_o = 4'h0;
        if (rd_index_in <= LAST_IDX) begin
            ra_o = r_fr_a[rd_index_in];
            rb_o = r_fr_b[rd_index_in];
        end
    end

    assign snap_valid_o = r_snap_valid;
    assign busy_o       = (r_state != ST_IDLE);

    ws_pace_strobe #(
        .PERIOD(FETCH_PERIOD)
    ) u_pace (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .i_en     (r_snap_valid),
        .i_restart(w_copy),
        .o_strobe (fetch_strobe_o)
    );

endmodule

// File: tb/tb_ws_disp_snapshot.sv
// tb/tb_ws_disp_snapshot.sv - directed self-checking bench for ws_disp_snapshot
module tb_ws_disp_snapshot;

    logic       clk_in = 1'b0;
    logic       reset_in = 1'b0;
    logic       acq_in = 1'b0;
    logic       seq_word_start_in = 1'b0;
    logic       seq_nibble_valid_in = 1'b0;
    logic [3:0] a_nibble_in = 4'h0;
    logic [3:0] b_nibble_in = 4'h0;
    logic [3:0] rd_index_in = 4'h0;
    logic [3:0] ra_o;
    logic [3:0] rb_o;
    logic       fetch_strobe_o;
    logic       snap_valid_o;
    logic       busy_o;

    int n_checks = 0;
    int n_errors = 0;

    ws_disp_snapshot #(
        .FETCH_PERIOD(16)
    ) dut (
        .clk_in             (clk_in),
        .reset_in           (reset_in),
        .acq_in             (acq_in),
        .seq_word_start_in  (seq_word_start_in),
        .seq_nibble_valid_in(seq_nibble_valid_in),
        .a_nibble_in        (a_nibble_in),
        .b_nibble_in        (b_nibble_in),
        .rd_index_in        (rd_index_in),
        .ra_o               (ra_o),
        .rb_o               (rb_o),
        .fetch_strobe_o     (fetch_strobe_o),
        .snap_valid_o       (snap_valid_o),
        .busy_o             (busy_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic nib(input logic start, input logic [3:0] a, input logic [3:0] b, input logic acq);
        seq_word_start_in   = start;
        seq_nibble_valid_in = 1'b1;
        a_nibble_in         = a;
        b_nibble_in         = b;
        acq_in              = acq;
        tick();
        seq_word_start_in   = 1'b0;
        seq_nibble_valid_in = 1'b0;
        acq_in              = 1'b0;
    endtask

    task automatic acq_pulse();
        acq_in = 1'b1;
        tick();
        acq_in = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] idx, input logic [3:0] ea, input logic [3:0] eb);
        rd_index_in = idx;
        #1;
        chk({tag, "_ra"}, 8'(ra_o), 8'(ea));
        chk({tag, "_rb"}, 8'(rb_o), 8'(eb));
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_snap", 8'(snap_valid_o), 8'h0);
        chk("rst_busy", 8'(busy_o), 8'h0);
        chk("rst_strobe", 8'(fetch_strobe_o), 8'h0);
        rd("rst_rd5", 4'd5, 4'h0, 4'h0);
        tick();
        reset_in = 1'b1;
        tick();

        // Snapshot 1: A = 0..D, B = 2
        acq_pulse();
        chk("arm_busy", 8'(busy_o), 8'h1);
        for (int i = 0; i < 14; i++) nib(i == 0, 4'(i), 4'h2, 1'b0);
        chk("s1_done_busy", 8'(busy_o), 8'h1);
        chk("s1_done_snap", 8'(snap_valid_o), 8'h0);
        rd("s1_done_rd5", 4'd5, 4'h0, 4'h0);
        tick();
        chk("s1_snap", 8'(snap_valid_o), 8'h1);
        chk("s1_idle", 8'(busy_o), 8'h0);
        rd("s1_rd5", 4'd5, 4'h5, 4'h2);
        rd("s1_rd0", 4'd0, 4'h0, 4'h2);
        rd("s1_rd13", 4'd13, 4'hD, 4'h2);
        rd("s1_rd14", 4'd14, 4'h0, 4'h0);
        rd("s1_rd15", 4'd15, 4'h0, 4'h0);

        // Fetch strobe cadence: DONE+16, DONE+32
        for (int i = 0; i < 14; i++) tick();
        chk("pace_15", 8'(fetch_strobe_o), 8'h0);
        tick();
        chk("pace_16", 8'(fetch_strobe_o), 8'h1);
        tick();
        chk("pace_17", 8'(fetch_strobe_o), 8'h0);
        for (int i = 0; i < 15; i++) tick();
        chk("pace_32", 8'(fetch_strobe_o), 8'h1);
        tick();

        // Snapshot 2: A = F-i, B = 7, with a request raised mid-capture
        acq_pulse();
        for (int i = 0; i < 14; i++) begin
            nib(i == 0, 4'(15 - i), 4'h7, i == 5);
            if (i == 7) rd("s2_mid_rd5", 4'd5, 4'h5, 4'h2);
        end
        rd("s2_done_rd5", 4'd5, 4'h5, 4'h2);
        tick();
        rd("s2_rd5", 4'd5, 4'hA, 4'h7);
        chk("s2_rearm", 8'(busy_o), 8'h1);

        // Snapshot 3 from the next word start; stray nibbles in ARM ignored
        for (int i = 0; i < 3; i++) nib(1'b0, 4'hE, 4'hE, 1'b0);
        chk("s3_arm_wait", 8'(busy_o), 8'h1);
        for (int i = 0; i < 14; i++) nib(i == 0, 4'(i + 1), 4'h9, 1'b0);
        tick();
        rd("s3_rd5", 4'd5, 4'h6, 4'h9);
        rd("s3_rd0", 4'd0, 4'h1, 4'h9);
        chk("s3_idle", 8'(busy_o), 8'h0);

        // Snapshot 4: word start at cnt=7 restarts the capture
        acq_pulse();
        for (int i = 0; i < 7; i++) nib(i == 0, 4'hC, 4'hC, 1'b0);
        for (int i = 0; i < 13; i++) nib(i == 0, 4'(i + 3), 4'h4, 1'b0);
        chk("s4_not_done", 8'(busy_o), 8'h1);
        tick();
        chk("s4_still_cap", 8'(busy_o), 8'h1);
        rd("s4_hold_rd5", 4'd5, 4'h6, 4'h9);
        nib(1'b0, 4'hF, 4'h4, 1'b0);
        tick();
        rd("s4_rd5", 4'd5, 4'h8, 4'h4);
        rd("s4_rd0", 4'd0, 4'h3, 4'h4);
        rd("s4_rd12", 4'd12, 4'hF, 4'h4);
        rd("s4_rd13", 4'd13, 4'hF, 4'h4);

        // Sequencer activity while IDLE is ignored
        for (int i = 0; i < 4; i++) nib(i == 0, 4'h1, 4'h1, 1'b0);
        chk("idle_ignore", 8'(busy_o), 8'h0);

        // Reset at cnt=9
        acq_pulse();
        for (int i = 0; i < 9; i++) nib(i == 0, 4'h5, 4'h5, 1'b0);
        reset_in = 1'b0;
        #1;
        chk("arst_snap", 8'(snap_valid_o), 8'h0);
        chk("arst_busy", 8'(busy_o), 8'h0);
        chk("arst_strobe", 8'(fetch_strobe_o), 8'h0);
        rd("arst_rd5", 4'd5, 4'h0, 4'h0);
        rd("arst_rd14", 4'd14, 4'h0, 4'h0);
        tick();
        reset_in = 1'b1;
        tick();

        // No snapshot without a fresh request
        for (int i = 0; i < 14; i++) nib(i == 0, 4'h6, 4'h6, 1'b0);
        tick();
        chk("post_rst_snap", 8'(snap_valid_o), 8'h0);
        chk("post_rst_busy", 8'(busy_o), 8'h0);
        rd("post_rst_rd5", 4'd5, 4'h0, 4'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
